// File: rtl/edge_fetch_seq_pkg.sv
// Shared definitions for the path-count edge fetch sequencer.
package edge_fetch_seq_pkg;

  localparam int unsigned NODE_IDX_WIDTH_DEF  = 10;
  localparam int unsigned COUNTER_WIDTH_DEF   = 4;
  localparam int unsigned ACCUM_VAL_WIDTH_DEF = 24;
  localparam int unsigned EDGE_ADDR_WIDTH_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_NODE_RD  = 3'd1,
    ST_NODE_CAP = 3'd2,
    ST_EDGE_RD  = 3'd3,
    ST_EDGE_CAP = 3'd4,
    ST_EMIT     = 3'd5
  } state_t;

endpackage

// File: rtl/edge_fetch_seq.sv
// Expands one node at a time: reads its edge range from the node table, then
// fetches each edge destination and emits (dst, accum) toward the FIFO push side.
module edge_fetch_seq
  import edge_fetch_seq_pkg::*;
#(
  parameter int unsigned PARAM_NODE_IDX_WIDTH  = NODE_IDX_WIDTH_DEF,
  parameter int unsigned PARAM_COUNTER_WIDTH   = COUNTER_WIDTH_DEF,
  parameter int unsigned PARAM_ACCUM_VAL_WIDTH = ACCUM_VAL_WIDTH_DEF,
  parameter int unsigned PARAM_EDGE_ADDR_WIDTH = EDGE_ADDR_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start_run,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  req_node_idx,
  input  logic [PARAM_ACCUM_VAL_WIDTH-1:0] req_accum,
  output logic                             node_rd_en,
  output logic [PARAM_NODE_IDX_WIDTH-1:0]  node_idx,
  input  logic [PARAM_EDGE_ADDR_WIDTH-1:0] edge_base,
  input  logic [PARAM_COUNTER_WIDTH-1:0]   edge_count,
  output logic                             edge_rd_en,
  output logic [PARAM_EDGE_ADDR_WIDTH-1:0] edge_addr,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  edge_dst_idx,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [PARAM_NODE_IDX_WIDTH-1:0]  out_node_idx,
  output logic [PARAM_ACCUM_VAL_WIDTH-1:0] out_accum,
  output logic                             seq_done,
  output logic                             busy
);

  state_t                           r_state, w_next;
  logic [PARAM_NODE_IDX_WIDTH-1:0]  r_node_idx, r_out_node;
  logic [PARAM_ACCUM_VAL_WIDTH-1:0] r_accum, r_out_accum;
  logic [PARAM_COUNTER_WIDTH-1:0]   r_count, r_i, w_i_inc;
  logic [PARAM_EDGE_ADDR_WIDTH-1:0] r_edge_addr;
  logic                             w_load_req, w_node_cap, w_edge_cap, w_xfer, w_last;

  assign w_i_inc      = r_i + PARAM_COUNTER_WIDTH'(1);
  assign w_last       = (w_i_inc == r_count);
  assign busy         = (r_state != ST_IDLE);
  assign node_idx     = r_node_idx;
  assign edge_addr    = r_edge_addr;
  assign out_node_idx = r_out_node;
  assign out_accum    = r_out_accum;

  // Every strobe is gated by start_run so a paused run shows no activity at all.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    node_rd_en = 1'b0;
    edge_rd_en = 1'b0;
    out_valid  = 1'b0;
    seq_done   = 1'b0;
    w_load_req = 1'b0;
    w_node_cap = 1'b0;
    w_edge_cap = 1'b0;
    w_xfer     = 1'b0;
    if (start_run) begin
      unique case (r_state)
        ST_IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            w_load_req = 1'b1;
            w_next     = ST_NODE_RD;
          end
        end
        ST_NODE_RD: begin
          node_rd_en = 1'b1;
          w_next     = ST_NODE_CAP;
        end
        ST_NODE_CAP: begin
          w_node_cap = 1'b1;
          if (edge_count == '0) begin
            seq_done = 1'b1;
            w_next   = ST_IDLE;
          end else begin
            w_next   = ST_EDGE_RD;
          end
        end
        ST_EDGE_RD: begin
          edge_rd_en = 1'b1;
          w_next     = ST_EDGE_CAP;
        end
        ST_EDGE_CAP: begin
          w_edge_cap = 1'b1;
          w_next     = ST_EMIT;
        end
        ST_EMIT: begin
          out_valid = 1'b1;
          if (out_ready) begin
            w_xfer = 1'b1;
            if (w_last) begin
              seq_done = 1'b1;
              w_next   = ST_IDLE;
            end else begin
              w_next   = ST_EDGE_RD;
            end
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The edge address is kept as a running pointer rather than base+i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_node_idx  <= '0;
      r_accum     <= '0;
      r_count     <= '0;
      r_i         <= '0;
      r_edge_addr <= '0;
      r_out_node  <= '0;
      r_out_accum <= '0;
    end else begin
      if (w_load_req) begin
        r_node_idx <= req_node_idx;
        r_accum    <= req_accum;
      end
      if (w_node_cap) begin
        r_count     <= edge_count;
        r_i         <= '0;
        r_edge_addr <= edge_base;
      end
      if (w_edge_cap) begin
        r_out_node  <= edge_dst_idx;
        r_out_accum <= r_accum;
      end
      if (w_xfer) begin
        r_i         <= w_i_inc;
        r_edge_addr <= r_edge_addr + PARAM_EDGE_ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_edge_fetch_seq.sv
// Directed bench for edge_fetch_seq with behavioural node-table and edge-memory models.
module tb_edge_fetch_seq;

  localparam logic [5:0] F_RR = 6'b100000;
  localparam logic [5:0] F_NR = 6'b010000;
  localparam logic [5:0] F_ER = 6'b001000;
  localparam logic [5:0] F_OV = 6'b000100;
  localparam logic [5:0] F_SD = 6'b000010;
  localparam logic [5:0] F_BZ = 6'b000001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_run = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  req_node_idx = '0;
  logic [23:0] req_accum = '0;
  logic        node_rd_en;
  logic [9:0]  node_idx;
  logic [11:0] edge_base = '0;
  logic [3:0]  edge_count = '0;
  logic        edge_rd_en;
  logic [11:0] edge_addr;
  logic [9:0]  edge_dst_idx = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [9:0]  out_node_idx;
  logic [23:0] out_accum;
  logic        seq_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  edge_fetch_seq #(
    .PARAM_NODE_IDX_WIDTH (10),
    .PARAM_COUNTER_WIDTH  (4),
    .PARAM_ACCUM_VAL_WIDTH(24),
    .PARAM_EDGE_ADDR_WIDTH(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_run(start_run),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_node_idx(req_node_idx), .req_accum(req_accum),
    .node_rd_en(node_rd_en), .node_idx(node_idx),
    .edge_base(edge_base), .edge_count(edge_count),
    .edge_rd_en(edge_rd_en), .edge_addr(edge_addr), .edge_dst_idx(edge_dst_idx),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_node_idx(out_node_idx), .out_accum(out_accum),
    .seq_done(seq_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Node table: 5 -> {0x010,3}, 7 -> {0xFFE,3}, everything else has no edges.
  logic [9:0] emem [0:4095];
  always @(posedge clk) begin
    if (node_rd_en) begin
      case (node_idx)
        10'd5:   begin edge_base <= 12'h010; edge_count <= 4'd3; end
        10'd7:   begin edge_base <= 12'hFFE; edge_count <= 4'd3; end
        default: begin edge_base <= 12'h000; edge_count <= 4'd0; end
      endcase
    end
    if (edge_rd_en) edge_dst_idx <= emem[edge_addr];
  end

  typedef struct {
    bit          run, vld, rdy;
    logic [9:0]  nidx;
    logic [23:0] acc;
    logic [5:0]  f;
    logic [11:0] addr;
    logic [9:0]  onode;
  } vec_t;

  vec_t        tbl[$];
  logic [9:0]  cur_node;
  logic [23:0] cur_acc;

  task automatic r(input bit run, input bit vld, input bit rdy, input logic [5:0] f,
                   input logic [11:0] addr, input logic [9:0] onode);
    vec_t v;
    v.run = run; v.vld = vld; v.rdy = rdy; v.nidx = cur_node; v.acc = cur_acc;
    v.f = f; v.addr = addr; v.onode = onode;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit run, input bit vld, input bit rdy);
    @(negedge clk);
    start_run = run; req_valid = vld; out_ready = rdy;
    #1;
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      @(negedge clk);
      start_run = tbl[k].run; req_valid = tbl[k].vld; out_ready = tbl[k].rdy;
      req_node_idx = tbl[k].nidx; req_accum = tbl[k].acc;
      #1;
      chk($sformatf("flags[%0d]", k),
          {26'd0, req_ready, node_rd_en, edge_rd_en, out_valid, seq_done, busy}, {26'd0, tbl[k].f});
      if (tbl[k].f[4]) chk($sformatf("node_idx[%0d]", k), {22'd0, node_idx}, {22'd0, tbl[k].nidx});
      if (tbl[k].f[3]) chk($sformatf("edge_addr[%0d]", k), {20'd0, edge_addr}, {20'd0, tbl[k].addr});
      if (tbl[k].f[2]) begin
        chk($sformatf("out_node[%0d]", k), {22'd0, out_node_idx}, {22'd0, tbl[k].onode});
        chk($sformatf("out_accum[%0d]", k), {8'd0, out_accum}, {8'd0, tbl[k].acc});
      end
    end
  endtask

  int xfers;
  bit done_seen;

  initial begin
    for (int a = 0; a < 4096; a++) emem[a] = '0;
    emem[12'h010] = 10'd7;  emem[12'h011] = 10'd8;  emem[12'h012] = 10'd9;
    emem[12'hFFE] = 10'd20; emem[12'hFFF] = 10'd21; emem[12'h000] = 10'd22;

    // A: node 5, accum 4, rows 0..12
    cur_node = 10'd5; cur_acc = 24'd4;
    r(1,1,1, F_RR, 0, 0);
    r(1,0,1, F_NR|F_BZ, 0, 0);
    r(1,0,1, F_BZ, 0, 0);
    r(1,0,1, F_ER|F_BZ, 12'h010, 0);
    r(1,0,1, F_BZ, 0, 0);
    r(1,0,1, F_OV|F_BZ, 0, 10'd7);
    r(1,0,1, F_ER|F_BZ, 12'h011, 0);
    r(1,0,1, F_BZ, 0, 0);
    r(1,0,1, F_OV|F_BZ, 0, 10'd8);
    r(1,0,1, F_ER|F_BZ, 12'h012, 0);
    r(1,0,1, F_BZ, 0, 0);
    r(1,0,1, F_OV|F_SD|F_BZ, 0, 10'd9);
    r(1,0,1, F_RR, 0, 0);
    // B: node 6 has zero edges
    cur_node = 10'd6; cur_acc = 24'd1;
    r(1,1,1, F_RR, 0, 0);
    r(1,0,1, F_NR|F_BZ, 0, 0);
    r(1,0,1, F_SD|F_BZ, 0, 0);
    r(1,0,1, F_RR, 0, 0);
    // C: node 5 with start_run low for 3 cycles in EDGE_CAP
    cur_node = 10'd5; cur_acc = 24'd4;
    r(1,1,1, F_RR, 0, 0);
    r(1,0,1, F_NR|F_BZ, 0, 0);
    r(1,0,1, F_BZ, 0, 0);
    r(1,0,1, F_ER|F_BZ, 12'h010, 0);
    r(0,0,1, F_BZ, 0, 0);
    r(0,0,1, F_BZ, 0, 0);
    r(0,0,1, F_BZ, 0, 0);
    r(1,0,1, F_BZ, 0, 0);
    r(1,0,1, F_OV|F_BZ, 0, 10'd7);
    r(1,0,1, F_ER|F_BZ, 12'h011, 0);
    r(1,0,1, F_BZ, 0, 0);
    r(1,0,1, F_OV|F_BZ, 0, 10'd8);
    r(1,0,1, F_ER|F_BZ, 12'h012, 0);
    r(1,0,1, F_BZ, 0, 0);
    r(1,0,1, F_OV|F_SD|F_BZ, 0, 10'd9);
    r(1,0,1, F_RR, 0, 0);
    // idle with start_run low: no ready, no accept
    r(0,1,1, 6'b0, 0, 0);
    r(0,1,1, 6'b0, 0, 0);
    // D: node 7 wraps the edge address; EMIT with run low must not transfer
    cur_node = 10'd7; cur_acc = 24'h123456;
    r(1,1,1, F_RR, 0, 0);
    r(1,0,1, F_NR|F_BZ, 0, 0);
    r(1,0,1, F_BZ, 0, 0);
    r(1,0,1, F_ER|F_BZ, 12'hFFE, 0);
    r(1,0,1, F_BZ, 0, 0);
    r(0,0,1, F_BZ, 0, 0);
    r(1,0,1, F_OV|F_BZ, 0, 10'd20);
    r(1,0,1, F_ER|F_BZ, 12'hFFF, 0);
    r(1,0,1, F_BZ, 0, 0);
    r(1,0,1, F_OV|F_BZ, 0, 10'd21);
    r(1,0,1, F_ER|F_BZ, 12'h000, 0);
    r(1,0,1, F_BZ, 0, 0);
    r(1,0,1, F_OV|F_SD|F_BZ, 0, 10'd22);
    r(1,0,1, F_RR, 0, 0);

    // Reset state
    #12;
    chk("reset_flags", {26'd0, req_ready, node_rd_en, edge_rd_en, out_valid, seq_done, busy}, 32'd0);
    chk("reset_payload", {node_idx, out_node_idx, edge_addr}, 32'd0);
    chk("reset_accum", {8'd0, out_accum}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    apply_rows(0, tbl.size() - 1);

    // Stall: out_ready low for 4 cycles at the first EMIT
    req_node_idx = 10'd5; req_accum = 24'd4;
    step(1,1,0);
    chk("stall_accept", {31'd0, req_ready}, 32'd1);
    for (int c = 0; c < 4; c++) step(1,0,0);
    for (int c = 0; c < 4; c++) begin
      step(1,0,0);
      chk($sformatf("stall_hold[%0d]", c), {20'd0, out_valid, edge_rd_en, out_node_idx}, {20'd0, 1'b1, 1'b0, 10'd7});
      chk($sformatf("stall_accum[%0d]", c), {8'd0, out_accum}, 32'd4);
    end
    xfers = 0; done_seen = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      step(1,0,1);
      if (out_valid) xfers++;
      if (seq_done) done_seen = 1'b1;
    end
    chk("stall_done", {31'd0, done_seen}, 32'd1);
    chk("stall_xfers", xfers, 32'd3);
    chk("stall_last_node", {22'd0, out_node_idx}, 32'd9);

    // Reset pulse during EMIT
    step(1,1,0);
    for (int c = 0; c < 4; c++) step(1,0,0);
    step(1,0,0);
    chk("pre_rst_emit", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {30'd0, out_valid, busy}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(1,0,1);
      if (out_valid || seq_done || busy) done_seen = 1'b1;
    end
    chk("post_rst_quiet", {31'd0, done_seen}, 32'd0);
    apply_rows(0, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/edge_fetch_seq.md
EDGE_FETCH_SEQ -- requirements
Module: edge_fetch_seq

Interface
REQ-001 Parameter PARAM_NODE_IDX_WIDTH, default 10, node index width.
REQ-002 Parameter PARAM_COUNTER_WIDTH, default 4, edge-count width; a node has at most 15 edges.
REQ-003 Parameter PARAM_ACCUM_VAL_WIDTH, default 24, path-count accumulator width.
REQ-004 Parameter PARAM_EDGE_ADDR_WIDTH, default 12, edge-memory address width.
REQ-005 Port clk  in  1  single clock; all state changes on rising edge.
REQ-006 Port rst_n  in  1  asynchronous active-low reset.
REQ-007 Port start_run  in  1  run enable; when low, all state and outputs hold.
REQ-008 Port req_valid / req_ready  in / out  1 / 1  node request handshake from accumulator FIFO pop side.
REQ-009 Port req_node_idx / req_accum  in  NODE_IDX / ACCUM  node to expand and its accumulated value.
REQ-010 Port node_rd_en / node_idx  out  1 / NODE_IDX  node-table read strobe and address.
REQ-011 Port edge_base / edge_count  in  EDGE_ADDR / COUNTER  node-table read data, valid the cycle after node_rd_en.
REQ-012 Port edge_rd_en / edge_addr  out  1 / EDGE_ADDR  edge-memory read strobe and address.
REQ-013 Port edge_dst_idx  in  NODE_IDX  edge-memory read data, valid the cycle after edge_rd_en.
REQ-014 Port out_valid / out_ready  out / in  1 / 1  successor handshake toward the FIFO push side.
REQ-015 Port out_node_idx / out_accum  out  NODE_IDX / ACCUM  successor index and value to accumulate.
REQ-016 Port seq_done  out  1  one-cycle pulse when a node's expansion completes.
REQ-017 Port busy  out  1  high whenever FSM is not IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, NODE_RD, NODE_CAP, EDGE_RD, EDGE_CAP and EMIT, and SHALL advance only when start_run=1.
REQ-019 req_ready SHALL be 1 only in IDLE with start_run=1; on accept the block latches req_node_idx and req_accum and goes to NODE_RD.
REQ-020 NODE_RD SHALL assert node_rd_en for exactly one cycle with node_idx equal to the latched index, then go to NODE_CAP.
REQ-021 NODE_CAP SHALL latch edge_base and edge_count and clear the edge counter i; if edge_count=0 it pulses seq_done and returns to IDLE, otherwise it goes to EDGE_RD.
REQ-022 EDGE_RD SHALL assert edge_rd_en for one cycle with edge_addr=(edge_base+i) mod 2^EDGE_ADDR_WIDTH, with wrap-around permitted, then go to EDGE_CAP.
REQ-023 EDGE_CAP SHALL load out_node_idx from edge_dst_idx and out_accum from the latched accum, unmodified, then go to EMIT.
REQ-024 EMIT SHALL hold out_valid=1 with stable payload until out_ready=1; on transfer, i increments.
REQ-025 On transfer, if i+1=edge_count the block pulses seq_done in the same cycle and returns to IDLE, else it goes to EDGE_RD.
REQ-026 Latency: request accepted in cycle T gives node_rd_en at T+1, edge_rd_en at T+3 and out_valid at T+5; each further edge adds 3 cycles plus stall cycles.
REQ-027 out_ready=1 with start_run=0 SHALL NOT transfer.
REQ-028 out_valid, node_rd_en, edge_rd_en and seq_done SHALL be 0 whenever start_run=0.
REQ-029 Only one node SHALL be in flight at a time; req_ready stays 0 until return to IDLE.
REQ-030 All output payloads SHALL be registered.

Reset
REQ-031 On rst_n=0, the FSM SHALL go to IDLE at once, without waiting for a clock edge.
REQ-032 On rst_n=0, all outputs and internal registers SHALL clear to 0, so req_ready=0 until start_run=1.
REQ-033 Reset mid-expansion SHALL abandon the node; no out_valid or seq_done appears afterward until a new request.

Structure
REQ-034 State encodings and default parameter values SHALL reside in a shared package used by the path-count top.
REQ-035 No sub-module is required; the optional output holding register SHALL be named out_slot if split out.

Verification
REQ-036 Node 5 (base=0x010, count=3, dsts 7,8,9), accum=4, out_ready=1: outputs (7,4), (8,4), (9,4) at T+5, T+8, T+11, with seq_done at T+11.
REQ-037 Node count=0: no out_valid; seq_done at T+2; req_ready=1 at T+3.
REQ-038 out_ready=0 for 4 cycles at first EMIT: payload is stable, edge_rd_en is not asserted, and exactly 3 transfers occur.
REQ-039 base=0xFFE, count=3: edge_addr sequence is 0xFFE, 0xFFF, 0x000.
REQ-040 start_run dropped for 3 cycles in EDGE_CAP: the FSM holds and the strobes are 0; resuming gives the same outputs as in REQ-036.
REQ-041 rst_n pulsed low during EMIT: out_valid=0 and busy=0 immediately; a new request afterward behaves as in REQ-036.
